// File: rtl/boot_load_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : boot_load_ctrl_if
// Brief    : Host word stream, cache write ports and run status of the boot
//            sequencer, bundled for connection to boot_load_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface boot_load_ctrl_if;
    logic [31:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        abort;
    logic [31:0] IData_in;
    logic [31:0] IAddr_in;
    logic        icache_we;
    logic [31:0] DData_in;
    logic [31:0] DAddr_in;
    logic        dcache_we;
    logic        start;
    logic        done;
    logic [23:0] run_count;
    logic        load_err;

    modport master (
        output host_data, host_valid, abort,
        input  host_ready, IData_in, IAddr_in, icache_we, DData_in, DAddr_in,
        input  dcache_we, start, done, run_count, load_err
    );

    modport slave (
        input  host_data, host_valid, abort,
        output host_ready, IData_in, IAddr_in, icache_we, DData_in, DAddr_in,
        output dcache_we, start, done, run_count, load_err
    );
endinterface
`default_nettype wire

// File: rtl/boot_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : boot_load_ctrl
// Brief    : Decodes host segment headers, writes payload through the icache /
//            dcache write ports, then releases and times the processor run.
// Revision : 1.0 - initial release
// ============================================================================
module boot_load_ctrl #(
    parameter int AW          = 16,
    parameter int START_DELAY = 2,
    parameter int RUN_CYCLES  = 400
) (
    input  wire logic         clk,
    input  wire logic         rst,
    boot_load_ctrl_if.slave   bus
);

    localparam logic [2:0]  c_ST_HDR   = 3'd0;
    localparam logic [2:0]  c_ST_DATA  = 3'd1;
    localparam logic [2:0]  c_ST_DELAY = 3'd2;
    localparam logic [2:0]  c_ST_RUN   = 3'd3;
    localparam logic [2:0]  c_ST_DONE  = 3'd4;

    localparam logic [7:0]  c_START_DELAY = 8'(START_DELAY);
    localparam logic [23:0] c_RUN_CYCLES  = 24'(RUN_CYCLES);

    logic [2:0]    r_state;
    logic          r_tgt;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_rem;
    logic          r_wrapped;
    logic [7:0]    r_dly;
    logic [23:0]   r_run_count;
    logic          r_done;
    logic          r_err;
    logic          r_start;
    logic          r_iwe;
    logic          r_dwe;
    logic [31:0]   r_idata;
    logic [31:0]   r_iaddr;
    logic [31:0]   r_ddata;
    logic [31:0]   r_daddr;

    logic          w_ready;
    logic          w_acc;
    logic [AW-1:0] w_base;
    logic [23:0]   w_rc_inc;

    // Abort and reset both gate the handshake combinationally so no word slips in.
    assign w_ready  = !rst && !bus.abort &&
                      ((r_state == c_ST_HDR) || (r_state == c_ST_DATA));
    assign w_acc    = w_ready && bus.host_valid;
    assign w_base   = AW'(bus.host_data[29:16]);
    assign w_rc_inc = r_run_count + 24'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_HDR;
            r_tgt       <= 1'b0;
            r_last      <= 1'b0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_wrapped   <= 1'b0;
            r_dly       <= '0;
            r_run_count <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_start     <= 1'b0;
            r_iwe       <= 1'b0;
            r_dwe       <= 1'b0;
            r_idata     <= '0;
            r_iaddr     <= '0;
            r_ddata     <= '0;
            r_daddr     <= '0;
        end else begin
            r_iwe <= 1'b0;
            r_dwe <= 1'b0;
            if (bus.abort) begin
                r_state <= c_ST_HDR;
                r_start <= 1'b0;
                r_rem   <= '0;
                if ((r_state == c_ST_RUN) || (r_state == c_ST_DONE)) begin
                    r_run_count <= '0;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                end
            end else begin
                case (r_state)
                    c_ST_HDR: begin
                        if (w_acc) begin
                            r_tgt     <= bus.host_data[31];
                            r_last    <= bus.host_data[30];
                            r_addr    <= w_base;
                            r_rem     <= bus.host_data[15:0];
                            r_wrapped <= 1'b0;
                            r_dly     <= '0;
                            if (bus.host_data[15:0] != 16'd0) begin
                                r_state <= c_ST_DATA;
                            end else if (bus.host_data[30]) begin
                                r_state <= c_ST_DELAY;
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (w_acc) begin
                            if (r_tgt) begin
                                r_dwe   <= 1'b1;
                                r_ddata <= bus.host_data;
                                r_daddr <= 32'(r_addr);
                            end else begin
                                r_iwe   <= 1'b1;
                                r_idata <= bus.host_data;
                                r_iaddr <= 32'(r_addr);
                            end
                            // Flag lands with the first strobe at a wrapped address.
                            if (r_wrapped) begin
                                r_err <= 1'b1;
                            end
                            if (r_addr == {AW{1'b1}}) begin
                                r_wrapped <= 1'b1;
                            end
                            r_addr <= r_addr + 1'b1;
                            r_rem  <= r_rem - 16'd1;
                            r_dly  <= '0;
                            if (r_rem == 16'd1) begin
                                r_state <= r_last ? c_ST_DELAY : c_ST_HDR;
                            end
                        end
                    end
                    c_ST_DELAY: begin
                        // The first DELAY cycle is the final strobe itself, so we count to START_DELAY inclusive.
                        if (r_dly == c_START_DELAY) begin
                            r_state <= c_ST_RUN;
                            r_start <= 1'b1;
                        end else begin
                            r_dly <= r_dly + 8'd1;
                        end
                    end
                    c_ST_RUN: begin
                        if (r_run_count != {24{1'b1}}) begin
                            r_run_count <= w_rc_inc;
                        end
                        if (w_rc_inc == c_RUN_CYCLES) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
                    end
                    c_ST_DONE: begin
                    end
                    default: begin
                        r_state <= c_ST_HDR;
                    end
                endcase
            end
        end
    end

    assign bus.host_ready = w_ready;
    assign bus.IData_in   = r_idata;
    assign bus.IAddr_in   = r_iaddr;
    assign bus.icache_we  = r_iwe;
    assign bus.DData_in   = r_ddata;
    assign bus.DAddr_in   = r_daddr;
    assign bus.dcache_we  = r_dwe;
    assign bus.start      = r_start;
    assign bus.done       = r_done;
    assign bus.run_count  = r_run_count;
    assign bus.load_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_boot_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_boot_load_ctrl
// Brief    : Drives a 16-bit and a 4-bit address instance with one host stream
//            and compares both against a segment-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_load_ctrl;
    localparam int START_DELAY = 2;
    localparam int RUN_CYCLES  = 400;
    localparam int P_HDR = 0, P_DATA = 1, P_DELAY = 2, P_RUN = 3, P_DONE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tb_data;
    logic        tb_valid;
    logic        tb_abort;

    boot_load_ctrl_if bus0 ();
    boot_load_ctrl_if bus1 ();

    assign bus0.host_data  = tb_data;
    assign bus0.host_valid = tb_valid;
    assign bus0.abort      = tb_abort;
    assign bus1.host_data  = tb_data;
    assign bus1.host_valid = tb_valid;
    assign bus1.abort      = tb_abort;

    boot_load_ctrl #(.AW(16), .START_DELAY(START_DELAY), .RUN_CYCLES(RUN_CYCLES))
        dut (.clk(clk), .rst(rst), .bus(bus0));
    boot_load_ctrl #(.AW(4), .START_DELAY(START_DELAY), .RUN_CYCLES(RUN_CYCLES))
        dut_w (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    logic [31:0] ob_idata[2], ob_iaddr[2], ob_ddata[2], ob_daddr[2];
    logic        ob_iwe[2], ob_dwe[2], ob_start[2], ob_done[2], ob_err[2], ob_hr[2];
    logic [23:0] ob_rc[2];
    assign ob_idata[0] = bus0.IData_in;  assign ob_idata[1] = bus1.IData_in;
    assign ob_iaddr[0] = bus0.IAddr_in;  assign ob_iaddr[1] = bus1.IAddr_in;
    assign ob_ddata[0] = bus0.DData_in;  assign ob_ddata[1] = bus1.DData_in;
    assign ob_daddr[0] = bus0.DAddr_in;  assign ob_daddr[1] = bus1.DAddr_in;
    assign ob_iwe[0]   = bus0.icache_we; assign ob_iwe[1]   = bus1.icache_we;
    assign ob_dwe[0]   = bus0.dcache_we; assign ob_dwe[1]   = bus1.dcache_we;
    assign ob_start[0] = bus0.start;     assign ob_start[1] = bus1.start;
    assign ob_done[0]  = bus0.done;      assign ob_done[1]  = bus1.done;
    assign ob_err[0]   = bus0.load_err;  assign ob_err[1]   = bus1.load_err;
    assign ob_hr[0]    = bus0.host_ready; assign ob_hr[1]   = bus1.host_ready;
    assign ob_rc[0]    = bus0.run_count; assign ob_rc[1]    = bus1.run_count;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int last_iwe = -1, start_rise = -1, n_we0 = 0;
    logic prev_start = 1'b0;
    logic [63:0] wq0[$];
    logic [32:0] wq1[$];
    logic [31:0] pl_data[23];

    // Reference model: one entry per instance, described in segment terms.
    int          m_ph[2], m_rem[2], m_dly[2], m_rc[2];
    longint      m_addr[2];
    bit          m_tgt[2], m_last[2], m_start[2], m_done[2], m_err[2], m_iwe[2], m_dwe[2];
    logic [31:0] m_idata[2], m_iaddr[2], m_ddata[2], m_daddr[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int k);
        return !rst && !tb_abort && (m_ph[k] == P_HDR || m_ph[k] == P_DATA);
    endfunction

    task automatic m_step(input int k, input bit acc);
        longint span = (k == 0) ? 64'd65536 : 64'd16;
        m_iwe[k] = 0;
        m_dwe[k] = 0;
        if (rst) begin
            m_ph[k] = P_HDR;  m_rem[k] = 0;  m_rc[k] = 0;  m_start[k] = 0;
            m_done[k] = 0;    m_err[k] = 0;
            m_idata[k] = '0;  m_iaddr[k] = '0;  m_ddata[k] = '0;  m_daddr[k] = '0;
        end else if (tb_abort) begin
            if (m_ph[k] == P_RUN || m_ph[k] == P_DONE) begin
                m_rc[k] = 0;  m_done[k] = 0;  m_err[k] = 0;
            end
            m_ph[k] = P_HDR;  m_start[k] = 0;  m_rem[k] = 0;
        end else begin
            case (m_ph[k])
                P_HDR: if (acc) begin
                    m_tgt[k]  = tb_data[31];
                    m_last[k] = tb_data[30];
                    m_addr[k] = longint'(tb_data[29:16]) % span;
                    m_rem[k]  = int'(tb_data[15:0]);
                    m_dly[k]  = START_DELAY + 1;
                    if (m_rem[k] != 0) m_ph[k] = P_DATA;
                    else if (m_last[k]) m_ph[k] = P_DELAY;
                end
                P_DATA: if (acc) begin
                    if (m_tgt[k]) begin
                        m_dwe[k] = 1;  m_ddata[k] = tb_data;  m_daddr[k] = 32'(m_addr[k] % span);
                    end else begin
                        m_iwe[k] = 1;  m_idata[k] = tb_data;  m_iaddr[k] = 32'(m_addr[k] % span);
                    end
                    if (m_addr[k] >= span) m_err[k] = 1;
                    m_addr[k]++;
                    m_rem[k]--;
                    if (m_rem[k] == 0) m_ph[k] = m_last[k] ? P_DELAY : P_HDR;
                end
                P_DELAY: begin
                    m_dly[k]--;
                    if (m_dly[k] == 0) begin
                        m_ph[k] = P_RUN;
                        m_start[k] = 1;
                    end
                end
                P_RUN: begin
                    if (m_rc[k] < 24'hFFFFFF) m_rc[k]++;
                    if (m_rc[k] == RUN_CYCLES) begin
                        m_done[k] = 1;
                        m_ph[k] = P_DONE;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare(input int k);
        chk($sformatf("icache_we[%0d]", k), 64'(ob_iwe[k]), 64'(m_iwe[k]));
        chk($sformatf("dcache_we[%0d]", k), 64'(ob_dwe[k]), 64'(m_dwe[k]));
        chk($sformatf("we_exclusive[%0d]", k), 64'(ob_iwe[k] && ob_dwe[k]), 64'd0);
        chk($sformatf("icache_data_addr[%0d]", k), {ob_idata[k], ob_iaddr[k]}, {m_idata[k], m_iaddr[k]});
        chk($sformatf("dcache_data_addr[%0d]", k), {ob_ddata[k], ob_daddr[k]}, {m_ddata[k], m_daddr[k]});
        chk($sformatf("start_done_err[%0d]", k), 64'({ob_start[k], ob_done[k], ob_err[k]}),
            64'({m_start[k], m_done[k], m_err[k]}));
        chk($sformatf("run_count[%0d]", k), 64'(ob_rc[k]), 64'(m_rc[k]));
    endtask

    // One clock: check the combinational handshake, advance the model, then check registers.
    task automatic cycle(output bit acc);
        #1;
        chk("host_ready[0]", 64'(ob_hr[0]), 64'(m_ready(0)));
        chk("host_ready[1]", 64'(ob_hr[1]), 64'(m_ready(1)));
        acc = tb_valid && m_ready(0);
        m_step(0, acc);
        m_step(1, acc);
        @(negedge clk);
        cyc++;
        compare(0);
        compare(1);
        if (ob_iwe[0] === 1'b1) begin
            last_iwe = cyc;
            wq0.push_back({ob_iaddr[0], ob_idata[0]});
        end
        if (ob_iwe[0] === 1'b1 || ob_dwe[0] === 1'b1) n_we0++;
        if (ob_iwe[1] === 1'b1) wq1.push_back({ob_err[1], ob_iaddr[1]});
        if (ob_dwe[1] === 1'b1) wq1.push_back({ob_err[1], ob_daddr[1]});
        if (ob_start[0] === 1'b1 && prev_start === 1'b0) start_rise = cyc;
        prev_start = ob_start[0];
    endtask

    task automatic send(input logic [31:0] w, input bit gaps);
        bit acc = 0;
        int tries = 0;
        tb_data = w;
        while (!acc && tries < 200) begin
            tb_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            cycle(acc);
            tries++;
        end
        tb_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%08h not accepted, expected acceptance", w);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        tb_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tb_data = $urandom;
            cycle(acc);
        end
    endtask

    task automatic do_abort();
        bit acc;
        tb_abort = 1'b1;
        tb_valid = 1'b1;
        tb_data  = $urandom;
        cycle(acc);
        tb_abort = 1'b0;
        tb_valid = 1'b0;
    endtask

    task automatic do_rst();
        bit acc;
        rst = 1'b1;
        tb_valid = 1'($urandom);
        cycle(acc);
        rst = 1'b0;
        tb_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int hdr_cyc, n;
        logic [31:0] hdr;
        logic [31:0] dseg[5] = '{32'd42, 32'd23, 32'd16, 32'd8, 32'd156};
        logic [32:0] wexp[4] = '{{1'b0, 32'd14}, {1'b0, 32'd15}, {1'b1, 32'd0}, {1'b1, 32'd1}};

        rst = 1'b1;  tb_valid = 1'b0;  tb_abort = 1'b0;  tb_data = '0;
        cycle(acc);
        cycle(acc);
        rst = 1'b0;
        chk("reset_outputs", {ob_start[0], ob_done[0], ob_err[0], ob_iwe[0], ob_dwe[0], ob_rc[0]}, '0);

        // Program load into icache.
        wq0.delete();
        send(32'h0000_0017, 0);
        for (int i = 0; i < 23; i++) begin
            pl_data[i] = $urandom;
            send(pl_data[i], 0);
        end
        idle(2);
        chk("load_strobe_count", 64'(wq0.size()), 64'd23);
        for (int i = 0; i < 23 && i < wq0.size(); i++)
            chk($sformatf("load_word_%0d", i), wq0[i], {32'(i), pl_data[i]});

        // dcache segment with host gaps.
        send(32'h8010_0008, 0);
        for (int i = 0; i < 8; i++) send($urandom, 1);
        idle(1);

        // Reset two words into a five-word segment.
        send(32'h0000_0005, 0);
        send($urandom, 0);
        send($urandom, 0);
        do_rst();
        n_we0 = 0;
        idle(4);
        chk("no_strobe_after_rst", 64'(n_we0), 64'd0);

        // Random non-final segments, some cut short by abort.
        for (int s = 0; s < 6; s++) begin
            hdr = {1'($urandom), 1'b0, 14'($urandom), 16'($urandom_range(1, 6))};
            send(hdr, 1);
            n = ($urandom_range(0, 3) == 0) ? int'(hdr[15:0]) / 2 : int'(hdr[15:0]);
            for (int i = 0; i < n; i++) send($urandom, 1);
            if (n != int'(hdr[15:0])) do_abort();
            idle($urandom_range(0, 2));
        end

        // Full boot: dcache constants, then final icache segment.
        send(32'h8000_0005, 0);
        for (int i = 0; i < 5; i++) send(dseg[i], 0);
        send(32'h4000_0017, 0);
        for (int i = 0; i < 23; i++) send($urandom, $urandom_range(0, 1) == 1);
        start_rise = -1;
        n = 0;
        while (!m_done[0] && n < 1000) begin
            idle(1);
            n++;
        end
        chk("boot_start_latency", 64'(start_rise - last_iwe), 64'(START_DELAY + 1));
        chk("boot_run_count", 64'(ob_rc[0]), 64'd400);
        chk("boot_done", 64'(ob_done[0]), 64'd1);
        idle(5);
        chk("done_sticky", 64'({ob_done[0], ob_start[0]}), 64'b11);
        do_abort();

        // Zero-count final segment.
        n_we0 = 0;
        start_rise = -1;
        send(32'hC000_0000, 0);
        hdr_cyc = cyc;
        n = 0;
        while (m_rc[0] != 100 && n < 500) begin
            idle(1);
            n++;
        end
        chk("zero_seg_start_latency", 64'(start_rise - hdr_cyc), 64'(START_DELAY + 1));
        chk("zero_seg_no_strobe", 64'(n_we0), 64'd0);
        chk("run_count_before_abort", 64'(ob_rc[0]), 64'd100);
        do_abort();
        #1;
        chk("abort_in_run", {ob_start[0], ob_rc[0], ob_hr[0]}, {1'b0, 24'd0, 1'b1});

        // Address wrap on the 4-bit instance.
        do_rst();
        wq1.delete();
        send(32'h000E_0004, 0);
        for (int i = 0; i < 4; i++) send($urandom, 0);
        idle(2);
        chk("wrap_count", 64'(wq1.size()), 64'd4);
        for (int i = 0; i < 4 && i < wq1.size(); i++)
            chk($sformatf("wrap_write_%0d", i), 64'(wq1[i]), 64'(wexp[i]));
        chk("no_wrap_err_aw16", 64'(ob_err[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
Boot sequencer that sits between a host word stream and MIPS_top. It decodes segment headers from the host and writes the instruction and data words through the icache/dcache write ports. After the last segment it releases the processor via start. It then counts run cycles and flags completion or timeout, so benches and the board wrapper never drive the cache write ports by hand.

Parameters:
AW, 16, cache address width; IAddr_in/DAddr_in are 32 bits, zero-extended above AW.
START_DELAY, 2, idle cycles between the final write and start rising (1..255).
RUN_CYCLES, 400, run cycles before done asserts (1..2^24-1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
host_data  input  32  header or payload word
host_valid  input  1  host_data valid
host_ready  output  1  controller accepts host_data this cycle
abort  input  1  drop to HDR, deassert start
IData_in  output  32  icache write data
IAddr_in  output  32  icache write word address
icache_we  output  1  icache write enable
DData_in  output  32  dcache write data
DAddr_in  output  32  dcache write word address
dcache_we  output  1  dcache write enable
start  output  1  processor run enable
done  output  1  run window elapsed, sticky
run_count  output  24  cycles spent in RUN
load_err  output  1  payload word count overflowed address space, sticky

Behaviour:
- Reset, synchronous, active-high, one cycle:
  - all outputs are 0; state is HDR.
  - Reset mid-load or mid-run aborts everything. Cache contents are not cleared.
- Handshake: a word transfers when host_valid && host_ready on a rising clk edge.
- host_ready is 1 only in HDR and DATA, and never in the cycle reset is asserted.
- Header word fields:
  - [31] target: 0 = icache, 1 = dcache.
  - [30] last segment.
  - [29:16] base word address, zero-extended to AW.
  - [15:0] count N.
- States:
  - HDR: on accept, latch target, last, addr = base, remaining = N.
    - N == 0 and last = 1 → DELAY.
    - N == 0 and last = 0 → stay in HDR.
    - Otherwise → DATA.
  - DATA: each accepted word drives the selected port on the next cycle: XData_in = word, XAddr_in = addr, X_we = 1 for exactly one cycle.
    - The other port's we stays 0; write data/address hold their last value when we = 0.
    - addr increments mod 2^AW; remaining decrements.
    - On the accept that makes remaining 0: last → DELAY, else → HDR.
    - An address wrap (addr was 2^AW-1 and more words follow) sets load_err; the write still occurs at the wrapped address.
  - DELAY: counter runs START_DELAY cycles, beginning the cycle after the final write strobe, then → RUN.
  - RUN: start = 1; run_count increments every cycle and saturates at 2^24-1. When run_count reaches RUN_CYCLES, done = 1 and → DONE.
  - DONE: start stays 1 and done stays 1. The state is left only by rst or abort.
- abort, in any state except reset:
  - next cycle: state = HDR, start = 0, any pending we is suppressed, remaining is cleared.
  - done, load_err and run_count are cleared on the transition out of RUN/DONE only.
- Precedence: rst > abort > normal operation.
  - A host word offered in the same cycle as abort is not accepted (host_ready forced 0).
- Simultaneous icache and dcache writes are impossible by construction. A bench assertion must check that icache_we && dcache_we never occurs.
- Write latency: accept edge → we high one cycle later. Back-to-back accepts give back-to-back strobes with no bubble.

Test Plan:
- Program load: header 0x0000_0017 (icache, base 0, N = 23) + 23 words → icache_we pulses 23 cycles, IAddr_in = 0..22 with data in order; dcache_we = 0 throughout.
- Full boot: dcache header 0x8000_0005 with data 42, 23, 16, 8, 156, then icache header 0x4000_0017 with 23 words → start rises exactly START_DELAY + 1 cycles after the final icache_we; done = 1 after 400 RUN cycles; run_count = 400.
- Back-pressure and gaps: host_valid toggled randomly during DATA → one strobe per accepted word, addresses contiguous, no duplicates.
- Zero-count segment: header 0xC000_0000 (dcache, last, N = 0) → no we strobes; start rises after START_DELAY.
- Wrap: AW = 4, header base 14, N = 4 → addresses 14, 15, 0, 1; load_err = 1 after the third write.
- Abort/reset: abort in RUN at run_count = 100 → start = 0 and run_count = 0 next cycle, host_ready = 1; rst mid-DATA (2 of 5 words) → no further strobes, state HDR.
